// File: rtl/sdram_device_responder.sv
// sdram_device_responder: x8 SDR SDRAM device model with init tracking, bank state, CAS-latency reads and sticky errors
module sdram_device_responder #(
  parameter int ROW_WIDTH     = 13,
  parameter int COL_WIDTH     = 10,
  parameter int BANK_WIDTH    = 2,
  parameter int SDRADDR_WIDTH = 13,
  parameter int MEM_ROW_BITS  = 1,
  parameter int T_RCD         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cke,
  input  logic                     cs_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic [BANK_WIDTH-1:0]    ba,
  input  logic [SDRADDR_WIDTH-1:0] addr,
  input  logic                     dqm,
  input  logic [7:0]               dq_in,
  output logic [7:0]               dq_out,
  output logic                     dq_oe,
  output logic                     init_done,
  output logic [SDRADDR_WIDTH-1:0] mode_reg,
  output logic [15:0]              ref_count,
  output logic                     cmd_err,
  output logic [2:0]               err_code
);
  localparam int NB = 1 << BANK_WIDTH;
  localparam int RB = (MEM_ROW_BITS < ROW_WIDTH) ? MEM_ROW_BITS : ROW_WIDTH;
  localparam int IW = BANK_WIDTH + RB + COL_WIDTH;
  localparam int TW = $clog2(T_RCD + 1);
  localparam logic [2:0] WAIT_PALL = 3'd0, WAIT_REF1 = 3'd1, WAIT_REF2 = 3'd2, WAIT_MRS = 3'd3, READY = 3'd4;

  logic [2:0]    state, err_now;
  logic          cl2, v0, c0, v1;
  logic [NB-1:0] open_b;
  logic [RB-1:0] row_q [NB];
  logic [TW-1:0] trcd [NB];
  logic [7:0]    mem [1 << IW];
  logic [7:0]    rdata, d1;
  logic [IW-1:0] idx;
  logic sel, is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, any_cmd;
  logic ready, init_ok, mrs_ok, bank_open, rw_ok, rd_ok, act_ok, pre_ok;

  assign init_done = state == READY;

  always_comb begin
    sel       = cke & ~cs_n;
    is_act    = sel & ({ras_n, cas_n, we_n} == 3'b011);
    is_rd     = sel & ({ras_n, cas_n, we_n} == 3'b101);
    is_wr     = sel & ({ras_n, cas_n, we_n} == 3'b100);
    is_pre    = sel & ({ras_n, cas_n, we_n} == 3'b010);
    is_ref    = sel & ({ras_n, cas_n, we_n} == 3'b001);
    is_mrs    = sel & ({ras_n, cas_n, we_n} == 3'b000);
    any_cmd   = sel & ({ras_n, cas_n, we_n} != 3'b111);
    ready     = state == READY;
    init_ok   = (is_pre & addr[10] & (state == WAIT_PALL)) |
                (is_ref & ((state == WAIT_REF1) | (state == WAIT_REF2))) |
                (is_mrs & (state == WAIT_MRS));
    bank_open = open_b[ba];
    mrs_ok    = ((addr[6:4] == 3'd2) | (addr[6:4] == 3'd3)) & (addr[2:0] == 3'd0) & (open_b == '0);
    err_now   = (any_cmd & ~(ready | init_ok))               ? 3'd5 :
                (is_mrs & ~mrs_ok)                            ? 3'd4 :
                ((is_rd | is_wr) & ~bank_open)                ? 3'd1 :
                (is_act & bank_open)                          ? 3'd2 :
                ((is_rd | is_wr) & (trcd[ba] != '0))          ? 3'd3 :
                (is_ref & ready & (open_b != '0))             ? 3'd6 : 3'd0;
    rw_ok     = ready & (is_rd | is_wr) & bank_open;
    rd_ok     = rw_ok & is_rd & ~dqm;
    act_ok    = ready & is_act & ~bank_open;
    pre_ok    = (ready | init_ok) & is_pre;
    idx       = {ba, row_q[ba], addr[COL_WIDTH-1:0]};
  end

  // Memory is never reset so contents survive a host-side reset
  always_ff @(posedge clk) begin
    if (rw_ok & is_wr & ~dqm) mem[idx] <= dq_in;
    rdata <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_PALL;
      cl2       <= 1'b0;
      open_b    <= '0;
      mode_reg  <= '0;
      ref_count <= '0;
      cmd_err   <= 1'b0;
      err_code  <= 3'd0;
      v0        <= 1'b0;
      c0        <= 1'b0;
      v1        <= 1'b0;
      d1        <= 8'd0;
      dq_oe     <= 1'b0;
      dq_out    <= 8'd0;
      for (int i = 0; i < NB; i++) trcd[i] <= '0;
    end else begin
      if (init_ok && err_now == 3'd0) state <= state + 3'd1;
      if ((ready | init_ok) & is_mrs & mrs_ok) begin
        mode_reg <= addr;
        cl2      <= addr[6:4] == 3'd2;
      end
      if (is_ref && ref_count != 16'hFFFF) ref_count <= ref_count + 16'd1;
      if (!cmd_err && err_now != 3'd0) begin
        cmd_err  <= 1'b1;
        err_code <= err_now;
      end
      for (int i = 0; i < NB; i++) begin
        if (act_ok && ba == i[BANK_WIDTH-1:0]) begin
          open_b[i] <= 1'b1;
          row_q[i]  <= addr[RB-1:0];
          trcd[i]   <= TW'(T_RCD - 1);
        end else if (trcd[i] != '0) trcd[i] <= trcd[i] - TW'(1);
        if ((pre_ok & (addr[10] | (ba == i[BANK_WIDTH-1:0]))) | (rw_ok & addr[10] & (ba == i[BANK_WIDTH-1:0])))
          open_b[i] <= 1'b0;
      end
      // rdata is the RAM output register; CL2 beats skip the second stage
      v0     <= rd_ok;
      c0     <= cl2;
      v1     <= v0 & ~c0;
      d1     <= rdata;
      dq_oe  <= (v0 & c0) | v1;
      dq_out <= (v0 & c0) ? rdata : v1 ? d1 : 8'd0;
    end
  end
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb_sdram_device_responder: directed command sequences with a read-beat scoreboard checked by an independent monitor
module tb_sdram_device_responder;
  logic        clk = 0, rst = 1, cke = 1, cs_n = 1, ras_n = 1, cas_n = 1, we_n = 1, dqm = 0;
  logic [1:0]  ba = 0;
  logic [12:0] addr = 0;
  logic [7:0]  dq_in = 0;
  logic [7:0]  dq_out;
  logic        dq_oe, init_done, cmd_err;
  logic [12:0] mode_reg;
  logic [15:0] ref_count;
  logic [2:0]  err_code;

  typedef struct {int cyc; logic [7:0] d;} beat_t;
  beat_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0, cl_m = 3;

  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;

  sdram_device_responder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .dqm(dqm), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .init_done(init_done), .mode_reg(mode_reg), .ref_count(ref_count), .cmd_err(cmd_err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a, input logic m = 0, input logic [7:0] din = 0);
    cs_n = 0; {ras_n, cas_n, we_n} = c; ba = b; addr = a; dqm = m; dq_in = din;
    @(posedge clk); #1;
    cs_n = 1; {ras_n, cas_n, we_n} = 3'b111; dqm = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [1:0] b, input logic [12:0] a, input logic [7:0] exp);
    q.push_back('{cyc + cl_m, exp});
    cmd(C_RD, b, a);
  endtask

  task automatic do_init();
    cmd(C_PRE, 0, 13'h400); cmd(C_REF, 0, 0); cmd(C_REF, 0, 0); cmd(C_MRS, 0, 13'h230);
    cl_m = 3;
  endtask

  task automatic do_reset();
    rst = 1; cl_m = 3;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Monitor: every dq_oe cycle must match the oldest expected beat in data and cycle
  initial forever begin
    @(negedge clk);
    if (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL missed_beat: no dq_oe at cycle %0d, expected data 0x%0h", q[0].cyc, q[0].d);
      void'(q.pop_front());
    end
    if (dq_oe === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_beat: dq_oe=1 at cycle %0d with data 0x%0h, expected no beat", cyc, dq_out);
      end else begin
        beat_t e;
        e = q.pop_front();
        check("beat_cycle", cyc, e.cyc);
        check("beat_data", {24'd0, dq_out}, {24'd0, e.d});
      end
    end
  end

  initial begin
    idle(2);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_dq_out", dq_out, 0);
    check("rst_init_done", init_done, 0);
    check("rst_mode_reg", mode_reg, 0);
    check("rst_ref_count", ref_count, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_err_code", err_code, 0);
    rst = 0;
    cmd(C_PRE, 0, 13'h400); cmd(C_REF, 0, 0); cmd(C_REF, 0, 0);
    check("pre_mrs_init_done", init_done, 0);
    cmd(C_MRS, 0, 13'h230);
    check("init_done", init_done, 1);
    check("init_mode_reg", mode_reg, 13'h230);
    check("init_ref_count", ref_count, 2);
    check("init_cmd_err", cmd_err, 0);
    // write with auto-precharge, reopen, read back at CL3
    cmd(C_ACT, 1, 13'h0005); idle(2);
    cmd(C_WR, 1, 13'h403, 0, 8'hA5);
    cmd(C_ACT, 1, 13'h0005); idle(2);
    rd(1, 13'h403, 8'hA5); idle(5);
    check("t2_no_err", cmd_err, 0);
    cmd(C_ACT, 1, 13'h0005);
    check("t2_bank_idle_after_ap", cmd_err, 0);
    cmd(C_PRE, 1, 13'h000);
    // read to idle bank, then ACT to open bank keeps first code
    cmd(C_RD, 2, 13'h003); idle(5);
    check("t3_cmd_err", cmd_err, 1);
    check("t3_err_code", err_code, 1);
    cmd(C_ACT, 0, 0); idle(2); cmd(C_ACT, 0, 0);
    check("t3_err_code_held", err_code, 1);
    cmd(C_PRE, 0, 13'h400);
    // tRCD violation still returns data
    do_reset(); do_init();
    cmd(C_ACT, 0, 0); idle(2);
    cmd(C_WR, 0, 13'h407, 0, 8'h5A);
    cmd(C_ACT, 0, 0);
    rd(0, 13'h407, 8'h5A); idle(1);
    check("t4_err_trcd", err_code, 3);
    idle(4);
    // bad CAS latency leaves CL at 3; memory survives reset
    do_reset(); do_init();
    cmd(C_MRS, 0, 13'h270);
    check("t4_err_mode", err_code, 4);
    cmd(C_ACT, 1, 13'h0005); idle(2);
    rd(1, 13'h403, 8'hA5); idle(5);
    // CL2 reads, back-to-back, masked read
    cmd(C_MRS, 0, 13'h220); cl_m = 2;
    check("t5_mode_reg_cl2", mode_reg, 13'h220);
    check("t5_err_code_held", err_code, 4);
    cmd(C_ACT, 3, 13'h0001); idle(2);
    cmd(C_WR, 3, 13'h010, 0, 8'h3C);
    rd(3, 13'h010, 8'h3C);
    cmd(C_WR, 3, 13'h003, 0, 8'h11);
    cmd(C_WR, 3, 13'h004, 0, 8'h22);
    rd(3, 13'h003, 8'h11);
    rd(3, 13'h004, 8'h22);
    cmd(C_RD, 3, 13'h003, 1);
    idle(4);
    cmd(C_PRE, 0, 13'h400);
    cmd(C_MRS, 0, 13'h230); cl_m = 3;
    cmd(C_ACT, 3, 13'h0001); idle(2);
    rd(3, 13'h003, 8'h11);
    rd(3, 13'h004, 8'h22);
    rd(3, 13'h410, 8'h3C);
    idle(5);
    // reset right after a READ flushes the beat
    cmd(C_ACT, 1, 13'h0005); idle(2);
    cmd(C_RD, 1, 13'h003);
    do_reset(); idle(4);
    check("t6_dq_oe", dq_oe, 0);
    check("t6_init_done", init_done, 0);
    check("t6_mode_reg", mode_reg, 0);
    check("t6_err_code_clr", err_code, 0);
    do_init();
    check("t6_ref_count", ref_count, 2);
    cmd(C_ACT, 1, 13'h0005); idle(2);
    rd(1, 13'h003, 8'hA5); idle(4);
    cmd(C_REF, 0, 0);
    check("t6_err_ref_open", err_code, 6);
    check("t6_cmd_err", cmd_err, 1);
    check("t6_ref_count_inc", ref_count, 3);
    idle(10);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_device_responder.md
Name: sdram_device_responder

Overview:
- Synthesizable SDR SDRAM device-side responder for x8 parts.
- Decodes the command bus driven by the team's SDRAM host controller and tracks per-bank row state.
- Stores write data in internal block RAM and returns read data after the programmed CAS latency.
- Lets host controller RTL be exercised on-FPGA and in simulation without a physical SDRAM; reports protocol violations on sticky error outputs.

Parameters:
ROW_WIDTH, 13, row address bits
COL_WIDTH, 10, column address bits
BANK_WIDTH, 2, bank address bits
SDRADDR_WIDTH, 13, address bus width (max of ROW_WIDTH, COL_WIDTH)
MEM_ROW_BITS, 1, low row bits used to index internal memory
T_RCD, 2, minimum cycles from ACT to READ/WRITE on same bank

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
cke  input  1  clock enable; 0 = command ignored
cs_n  input  1  chip select; 1 = deselect (NOP)
ras_n  input  1  row strobe
cas_n  input  1  column strobe
we_n  input  1  write enable
ba  input  BANK_WIDTH  bank address
addr  input  SDRADDR_WIDTH  row/column/mode address; A10 = auto-precharge / all-banks
dqm  input  1  data mask
dq_in  input  8  data from host (write)
dq_out  output  8  read data to host
dq_oe  output  1  drive enable for dq_out
init_done  output  1  init sequence completed
mode_reg  output  SDRADDR_WIDTH  last accepted MRS value
ref_count  output  16  REF commands received, saturating
cmd_err  output  1  sticky protocol-error flag
err_code  output  3  code of first error since reset

Behaviour:
- Reset (rst=1 at posedge): dq_out=0, dq_oe=0, init_done=0, mode_reg=0, ref_count=0, cmd_err=0, err_code=0; all banks idle; read pipeline flushed; CL=3. Memory contents are not cleared. Reset mid-read: no data beat issued after reset.
- Command decode (cke=1, cs_n=0), {ras_n,cas_n,we_n}:
  - 111 NOP
  - 011 ACT
  - 101 READ
  - 100 WRITE
  - 010 PRE (A10=1: all banks)
  - 001 REF
  - 000 MRS
- cke=0 or cs_n=1: NOP.
- Init FSM: WAIT_PALL -> WAIT_REF1 -> WAIT_REF2 -> WAIT_MRS -> READY.
  - Advances on PRE with A10=1, then REF, then REF, then MRS.
  - NOP is always legal.
  - Any other command before READY: err 5; command has no effect; FSM does not advance.
  - init_done=1 on entering READY.
- MRS (legal in WAIT_MRS and READY, all banks idle): mode_reg<=addr.
  - CL=addr[6:4]. Only 2 or 3 accepted; anything else gives err 4 and CL stays unchanged.
  - addr[2:0]!=000 (burst length other than 1): err 4.
- ACT: bank must be idle, else err 2. Record open row = addr[ROW_WIDTH-1:0]. Per-bank tRCD counter loads T_RCD-1.
- READ/WRITE:
  - Bank must be open, else err 1 (no data, no write).
  - tRCD counter must be 0, else err 3; the access still executes.
  - Column = addr[COL_WIDTH-1:0].
  - Memory index = {ba, open_row[MEM_ROW_BITS-1:0], column]}; higher row bits alias.
  - A10=1: bank goes idle after the command.
- WRITE: mem[index]<=dq_in on the same edge when dqm=0. dqm=1 masks the write.
- READ:
  - Command sampled at edge k; dq_out/dq_oe registered at edge k+CL-1, so the host samples valid data at edge k+CL.
  - dq_oe high exactly one cycle per READ.
  - Back-to-back READs supported via a 3-deep shift pipeline.
  - dqm=1 at the READ edge suppresses that beat (dq_oe stays 0).
  - Write-then-read to the same index returns the new data.
- PRE: A10=1 idles all banks; A10=0 idles bank ba. PRE to an idle bank is legal.
- REF in READY: any bank open gives err 6 (refresh not performed). ref_count increments per REF, including during init; saturates at 0xFFFF.
- Errors:
  - Codes: 1 RW to idle bank, 2 ACT to open bank, 3 tRCD, 4 bad mode, 5 init sequence, 6 REF with open bank.
  - One command per cycle, so at most one error per cycle.
  - cmd_err sets on first error; err_code latches the first code and holds until rst.

Test Plan:
1. PRE(A10=1), REF, REF, MRS addr=0x230 -> init_done=1, mode_reg=0x230, ref_count=2, cmd_err=0.
2. After init: ACT ba=1 row=0x0005; 2 NOPs; WRITE col=0x003 A10=1 dq_in=0xA5 dqm=0; ACT ba=1 row=0x0005; 2 NOPs; READ col=0x003 -> dq_oe=1 for exactly one cycle, dq_out=0xA5 sampled at the 3rd edge after READ; bank 1 idle afterwards.
3. READ ba=2 with no prior ACT -> cmd_err=1, err_code=1, dq_oe never asserted. A subsequent ACT to an open bank leaves err_code=1.
4. ACT ba=0 then READ ba=0 on the next cycle (T_RCD=2) -> err_code=3, data still returned. MRS 0x270 (CL=7) after reset+init -> err_code=4, CL remains 3.
5. MRS 0x220, then write/read 0x3C -> data sampled at the 2nd edge after READ. Two consecutive READs to cols 3 and 4 (values 0x11, 0x22) -> two consecutive dq_oe cycles carrying 0x11 then 0x22.
6. READ issued, rst pulsed the following cycle -> dq_oe stays 0, init_done=0, mode_reg=0. Re-init and read the same location -> previously written value returned. REF with bank open in READY -> err_code=6.
